// File: rtl/video_window_timing_gen.sv
// video_window_timing_gen: raster timing generator for an arbitrary panel geometry.
// It fetches a WIN_W x WIN_H image from a 1-cycle synchronous RAM and replicates it
// SCALE times in both axes at (WIN_X0, WIN_Y0). A full-height white marker column
// is drawn on top. Sync, data enable, colour and frame_start share one 2-stage
// pipeline, and the RAM read is issued one cycle ahead of the output.
module video_window_timing_gen #(
    parameter int          H_ACTIVE     = 1366,
    parameter int          H_BLANK      = 50,
    parameter int          H_SYNC_START = 0,
    parameter int          H_SYNC_WIDTH = 25,
    parameter int          V_ACTIVE     = 767,
    parameter int          V_BLANK      = 12,
    parameter int          V_SYNC_START = 0,
    parameter int          V_SYNC_WIDTH = 6,
    parameter logic        SYNC_ACTIVE  = 1'b0,
    parameter int          WIN_W        = 100,
    parameter int          WIN_H        = 100,
    parameter int          WIN_X0       = 0,
    parameter int          WIN_Y0       = 0,
    parameter int          SCALE        = 4,
    parameter int          ADDR_W       = 14,
    parameter int          MARKER_COL   = 450,
    parameter logic        MARKER_EN    = 1'b1,
    parameter logic [23:0] BG_RGB       = 24'h000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [23:0]       pix_rgb,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_rd,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int X_LAST  = H_TOTAL - 1;
    localparam int Y_LAST  = V_TOTAL - 1;
    localparam int WIN_X1  = WIN_X0 + WIN_W * SCALE;
    localparam int WIN_Y1  = WIN_Y0 + WIN_H * SCALE;
    localparam int HS_LO   = H_ACTIVE + H_SYNC_START;
    localparam int HS_HI   = HS_LO + H_SYNC_WIDTH;
    localparam int VS_LO   = V_ACTIVE + V_SYNC_START;
    localparam int VS_HI   = VS_LO + V_SYNC_WIDTH;

    localparam logic [SW-1:0]     SCALE_LAST = SW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(WIN_W);

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    int                xi;
    int                yi;
    logic              line_end;
    logic              frame_end;
    logic              act0;
    logic              win_row0;
    logic              win_col0;
    logic              win0;
    logic              hs0;
    logic              vs0;
    logic              mk0;
    logic              fs0;

    logic [SW-1:0]     col_cnt;
    logic [SW-1:0]     row_cnt;
    logic [ADDR_W-1:0] addr_cur;
    logic [ADDR_W-1:0] row_base;

    logic              act1;
    logic              win1;
    logic              hs1;
    logic              vs1;
    logic              mk1;
    logic              fs1;
    logic              use_ram;
    logic [23:0]       rgb_hold;

    // Stage 0 decode of the raster position; the window is clipped to the active area
    always_comb begin
        xi        = int'(x);
        yi        = int'(y);
        line_end  = (xi == X_LAST);
        frame_end = line_end && (yi == Y_LAST);
        act0      = (xi < H_ACTIVE) && (yi < V_ACTIVE);
        win_row0  = (yi >= WIN_Y0) && (yi < WIN_Y1) && (yi < V_ACTIVE);
        win_col0  = (xi >= WIN_X0) && (xi < WIN_X1) && (xi < H_ACTIVE);
        win0      = win_row0 && win_col0;
        hs0       = (xi >= HS_LO) && (xi < HS_HI);
        vs0       = (yi >= VS_LO) && (yi < VS_HI);
        mk0       = MARKER_EN && act0 && (xi == MARKER_COL);
        fs0       = (x == '0) && (y == '0);
    end

    // Raster counters; they park on the last pixel of a frame until run is seen high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (frame_end) begin
            if (run) begin
                x <= '0;
                y <= '0;
            end
        end else if (line_end) begin
            x <= '0;
            y <= y + 1'b1;
        end else begin
            x <= x + 1'b1;
        end
    end

    // Incremental address: column sub-counter steps addr, line end reloads the row base
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            addr_cur <= '0;
            row_base <= '0;
        end else if (frame_end) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            addr_cur <= '0;
            row_base <= '0;
        end else if (line_end) begin
            col_cnt <= '0;
            if (win_row0 && (row_cnt == SCALE_LAST)) begin
                row_cnt  <= '0;
                row_base <= row_base + ROW_STEP;
                addr_cur <= row_base + ROW_STEP;
            end else begin
                if (win_row0) begin
                    row_cnt <= row_cnt + 1'b1;
                end
                addr_cur <= row_base;
            end
        end else if (win0) begin
            if (col_cnt == SCALE_LAST) begin
                col_cnt  <= '0;
                addr_cur <= addr_cur + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // RAM request, one cycle ahead of the output; the address holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_rd   <= 1'b0;
            pix_addr <= '0;
        end else begin
            pix_rd <= win0;
            if (win0) begin
                pix_addr <= addr_cur;
            end
        end
    end

    // Stage 1 carries the decoded flags alongside the outstanding RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act1 <= 1'b0;
            win1 <= 1'b0;
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            mk1  <= 1'b0;
            fs1  <= 1'b0;
        end else begin
            act1 <= act0;
            win1 <= win0;
            hs1  <= hs0;
            vs1  <= vs0;
            mk1  <= mk0;
            fs1  <= fs0;
        end
    end

    // Stage 2 output registers; RAM data arrives registered by the RAM itself this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            de          <= 1'b0;
            frame_start <= 1'b0;
            use_ram     <= 1'b0;
            rgb_hold    <= 24'h000000;
        end else begin
            hsync       <= hs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= vs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            de          <= act1;
            frame_start <= fs1;
            use_ram     <= win1 && !mk1;
            if (mk1) begin
                rgb_hold <= 24'hFFFFFF;
            end else if (act1 && !win1) begin
                rgb_hold <= BG_RGB;
            end else begin
                rgb_hold <= 24'h000000;
            end
        end
    end

    assign {red, green, blue} = use_ram ? pix_rgb : rgb_hold;

endmodule

// File: tb/tb_video_window_timing_gen.sv
// tb_video_window_timing_gen: directed checks of the window timing generator on a
// 20x11 raster. A second instance covers a window clipped by the active edges.
module tb_video_window_timing_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [23:0] pix_rgb = 24'h0;
    logic [5:0]  pix_addr;
    logic        pix_rd;
    logic        hsync, vsync, de, frame_start;
    logic [7:0]  red, green, blue;
    logic [23:0] rgbMain;

    logic [23:0] cpix_rgb = 24'h0;
    logic [5:0]  cpix_addr;
    logic        cpix_rd;
    logic        chsync, cvsync, cde, cframe_start;
    logic [7:0]  cred, cgreen, cblue;
    logic [23:0] rgbClip;

    int checks    = 0;
    int errors    = 0;
    int edgeCount = 0;
    int base      = 0;
    int deCount   = 0;
    int expL1[8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
    int expL3[8]  = '{4, 4, 5, 5, 6, 6, 7, 7};

    assign rgbMain = {red, green, blue};
    assign rgbClip = {cred, cgreen, cblue};

    video_window_timing_gen #(
        .H_ACTIVE(16), .H_BLANK(4), .H_SYNC_START(0), .H_SYNC_WIDTH(2),
        .V_ACTIVE(8), .V_BLANK(3), .V_SYNC_START(0), .V_SYNC_WIDTH(2),
        .SYNC_ACTIVE(1'b0), .WIN_W(4), .WIN_H(2), .WIN_X0(2), .WIN_Y0(1),
        .SCALE(2), .ADDR_W(6), .MARKER_COL(3), .MARKER_EN(1'b1), .BG_RGB(24'h123456)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .pix_rgb(pix_rgb),
        .pix_addr(pix_addr), .pix_rd(pix_rd), .hsync(hsync), .vsync(vsync),
        .de(de), .red(red), .green(green), .blue(blue), .frame_start(frame_start)
    );

    video_window_timing_gen #(
        .H_ACTIVE(16), .H_BLANK(4), .H_SYNC_START(0), .H_SYNC_WIDTH(2),
        .V_ACTIVE(8), .V_BLANK(3), .V_SYNC_START(0), .V_SYNC_WIDTH(2),
        .SYNC_ACTIVE(1'b0), .WIN_W(4), .WIN_H(4), .WIN_X0(14), .WIN_Y0(7),
        .SCALE(1), .ADDR_W(6), .MARKER_COL(3), .MARKER_EN(1'b0), .BG_RGB(24'h000000)
    ) u_dut_clip (
        .clk(clk), .rst_n(rst_n), .run(run), .pix_rgb(cpix_rgb),
        .pix_addr(cpix_addr), .pix_rd(cpix_rd), .hsync(chsync), .vsync(cvsync),
        .de(cde), .red(cred), .green(cgreen), .blue(cblue), .frame_start(cframe_start)
    );

    // Free-running pixel clock, period 10
    always #5 clk = ~clk;

    // Synchronous RAM models with 1-cycle read latency whose contents equal their address
    always @(posedge clk) begin
        if (pix_rd)  pix_rgb  <= 24'(pix_addr);
        if (cpix_rd) cpix_rgb <= 24'(cpix_addr);
    end

    function automatic int pix(input int px, input int py);
        return py * 20 + px;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edgeCount++;
    endtask

    task automatic gotoEdge(input int target);
        while (edgeCount < target) tick();
    endtask

    task automatic applyStimulus(input logic rstVal, input logic runVal);
        rst_n = rstVal;
        run   = runVal;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence; edge k after reset release puts the counter on pixel k
    initial begin
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("rst_hsync", hsync, 1);
        checkOutput("rst_vsync", vsync, 1);
        checkOutput("rst_de", de, 0);
        checkOutput("rst_rgb", rgbMain, 0);
        checkOutput("rst_fs", frame_start, 0);
        checkOutput("rst_rd", pix_rd, 0);
        checkOutput("rst_addr", pix_addr, 0);

        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        edgeCount = 0;
        $display("[TB] reset released");

        gotoEdge(1);
        checkOutput("fs_edge1", frame_start, 0);
        gotoEdge(2);
        checkOutput("fs_edge2", frame_start, 1);
        checkOutput("de_0_0", de, 1);
        checkOutput("rgb_0_0_bg", rgbMain, 24'h123456);
        checkOutput("hsync_0_0", hsync, 1);

        gotoEdge(base + pix(3, 0) + 2);
        checkOutput("marker_3_0", rgbMain, 24'hFFFFFF);

        gotoEdge(base + pix(16, 0) + 2);
        checkOutput("hsync_x16", hsync, 0);
        checkOutput("de_x16", de, 0);
        checkOutput("rgb_x16", rgbMain, 0);
        gotoEdge(base + pix(17, 0) + 2);
        checkOutput("hsync_x17", hsync, 0);
        gotoEdge(base + pix(18, 0) + 2);
        checkOutput("hsync_x18", hsync, 1);

        for (int x = 2; x <= 9; x++) begin
            gotoEdge(base + pix(x, 1) + 1);
            checkOutput("rd_l1", pix_rd, 1);
            checkOutput("addr_l1", pix_addr, expL1[x-2]);
            gotoEdge(base + pix(x, 1) + 2);
            checkOutput("rgb_l1", rgbMain, (x == 3) ? 24'hFFFFFF : 24'(expL1[x-2]));
        end
        gotoEdge(base + pix(10, 1) + 1);
        checkOutput("rd_10_1", pix_rd, 0);
        checkOutput("addr_hold_10_1", pix_addr, 3);
        gotoEdge(base + pix(10, 1) + 2);
        checkOutput("rgb_10_1_bg", rgbMain, 24'h123456);

        deCount = 0;
        for (int k = 42; k <= 61; k++) begin
            gotoEdge(k);
            deCount += int'(de);
        end
        checkOutput("de_per_line", deCount, 16);

        for (int x = 2; x <= 9; x++) begin
            gotoEdge(base + pix(x, 3) + 1);
            checkOutput("rd_l3", pix_rd, 1);
            checkOutput("addr_l3", pix_addr, expL3[x-2]);
            gotoEdge(base + pix(x, 3) + 2);
            checkOutput("rgb_l3", rgbMain, (x == 3) ? 24'hFFFFFF : 24'(expL3[x-2]));
        end

        gotoEdge(base + pix(5, 5) + 1);
        checkOutput("rd_5_5", pix_rd, 0);
        gotoEdge(base + pix(5, 5) + 2);
        checkOutput("rgb_5_5_bg", rgbMain, 24'h123456);

        gotoEdge(base + pix(14, 6) + 1);
        checkOutput("clip_rd_14_6", cpix_rd, 0);
        gotoEdge(base + pix(13, 7) + 1);
        checkOutput("clip_rd_13_7", cpix_rd, 0);
        gotoEdge(base + pix(14, 7) + 1);
        checkOutput("clip_rd_14_7", cpix_rd, 1);
        checkOutput("clip_addr_14_7", cpix_addr, 0);
        gotoEdge(base + pix(15, 7) + 1);
        checkOutput("clip_rd_15_7", cpix_rd, 1);
        checkOutput("clip_addr_15_7", cpix_addr, 1);
        gotoEdge(base + pix(16, 7) + 1);
        checkOutput("clip_rd_16_7", cpix_rd, 0);
        checkOutput("clip_addr_hold", cpix_addr, 1);
        checkOutput("clip_rgb_15_7", rgbClip, 1);

        gotoEdge(base + pix(19, 7) + 2);
        checkOutput("vsync_line7", vsync, 1);
        gotoEdge(base + pix(0, 8) + 2);
        checkOutput("vsync_line8", vsync, 0);
        checkOutput("de_line8", de, 0);
        gotoEdge(base + pix(0, 9) + 2);
        checkOutput("vsync_line9", vsync, 0);
        gotoEdge(base + pix(0, 10) + 2);
        checkOutput("vsync_line10", vsync, 1);

        gotoEdge(221);
        checkOutput("fs_221", frame_start, 0);
        gotoEdge(222);
        checkOutput("fs_222", frame_start, 1);

        gotoEdge(300);
        applyStimulus(1'b1, 1'b0);
        $display("[TB] run deasserted mid-frame");

        gotoEdge(220 + pix(14, 7) + 1);
        checkOutput("clip_addr_frame1", cpix_addr, 0);
        checkOutput("clip_rd_frame1", cpix_rd, 1);

        gotoEdge(441);
        checkOutput("park_de_441", de, 0);
        gotoEdge(460);
        checkOutput("park_fs_460", frame_start, 0);
        checkOutput("park_de_460", de, 0);
        gotoEdge(500);
        checkOutput("park_rd_500", pix_rd, 0);
        checkOutput("park_de_500", de, 0);
        checkOutput("park_vsync_500", vsync, 1);

        applyStimulus(1'b1, 1'b1);
        gotoEdge(502);
        checkOutput("restart_fs_502", frame_start, 0);
        gotoEdge(503);
        checkOutput("restart_fs_503", frame_start, 1);
        base = 501;

        gotoEdge(base + pix(2, 1) + 1);
        checkOutput("restart_rd_2_1", pix_rd, 1);
        checkOutput("restart_addr_2_1", pix_addr, 0);

        gotoEdge(base + pix(10, 5));
        checkOutput("pre_rst_de", de, 1);
        applyStimulus(1'b0, 1'b1);
        #1;
        checkOutput("async_hsync", hsync, 1);
        checkOutput("async_vsync", vsync, 1);
        checkOutput("async_de", de, 0);
        checkOutput("async_rgb", rgbMain, 0);
        checkOutput("async_fs", frame_start, 0);
        checkOutput("async_rd", pix_rd, 0);
        checkOutput("async_addr", pix_addr, 0);

        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        edgeCount = 0;
        base      = 0;
        gotoEdge(1);
        checkOutput("rerst_fs_edge1", frame_start, 0);
        checkOutput("rerst_de_edge1", de, 0);
        gotoEdge(2);
        checkOutput("rerst_fs_edge2", frame_start, 1);
        checkOutput("rerst_de_edge2", de, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_window_timing_gen.md
# video_window_timing_gen

Parametrised successor to the fixed-resolution LVDS test pattern generator. It produces raster timing (hsync, vsync, data enable) for any panel geometry and fetches a WIN_W×WIN_H image from an external synchronous RAM. The image is replicated SCALE× in both axes at a programmable origin, and a full-height white marker column is overlaid. Output feeds `video_lvds` (DotClock domain) directly; every output is registered and pipeline-aligned.

## Interface
- H_ACTIVE, 1366, active pixels per line
- H_BLANK, 50, blanking pixels per line
- H_SYNC_START, 0, hsync start offset into horizontal blanking
- H_SYNC_WIDTH, 25, hsync width in pixels
- V_ACTIVE, 767, active lines
- V_BLANK, 12, blanking lines
- V_SYNC_START, 0, vsync start offset into vertical blanking
- V_SYNC_WIDTH, 6, vsync width in lines
- SYNC_ACTIVE, 0, asserted level of hsync/vsync
- WIN_W, 100, source image width; WIN_H, 100, source image height
- WIN_X0, 0, window origin column; WIN_Y0, 0, window origin line
- SCALE, 4, replication factor, 1..16
- ADDR_W, 14, RAM address width; WIN_W*WIN_H ≤ 2^ADDR_W
- MARKER_COL, 450, marker column (active region only); MARKER_EN, 1, marker enable
- BG_RGB, 24'h000000, colour of active pixels outside window

Ports:
- clk  in  1  pixel clock (DotClock)
- rst_n  in  1  asynchronous active-low reset
- run  in  1  frame enable, sampled at last pixel of frame
- pix_rgb  in  24  RAM data {R,G,B}, valid one cycle after pix_rd
- pix_addr  out  ADDR_W  RAM read address
- pix_rd  out  1  RAM read strobe
- hsync, vsync  out  1  sync, level SYNC_ACTIVE when asserted
- de  out  1  data enable
- red, green, blue  out  8  pixel colour
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

## Operation
- Counters x ∈ [0, H_TOTAL−1], y ∈ [0, V_TOTAL−1], where H_TOTAL=H_ACTIVE+H_BLANK and V_TOTAL=V_ACTIVE+V_BLANK. x wraps to 0 and y increments on the same edge.
- Park: at (H_TOTAL−1, V_TOTAL−1) with run=0, counters hold. The first edge with run=1 moves them to (0,0). run is ignored at every other position; deassertion mid-frame completes the frame.
- Stage 0 (counter position), decoded:
  - act = x<H_ACTIVE && y<V_ACTIVE.
  - win = act && x∈[WIN_X0, WIN_X0+WIN_W·SCALE) && y∈[WIN_Y0, WIN_Y0+WIN_H·SCALE). The window is clipped to the active region.
  - hs = x∈[H_ACTIVE+H_SYNC_START, +H_SYNC_WIDTH).
  - vs = y∈[V_ACTIVE+V_SYNC_START, +V_SYNC_WIDTH).
- Address: addr = ((y−WIN_Y0)/SCALE)·WIN_W + (x−WIN_X0)/SCALE.
  - Generated incrementally, with no divider or multiplier: a column sub-counter steps addr every SCALE pixels.
  - At the end of each window line, addr reloads the row base. The base advances by WIN_W every SCALE lines.
  - Base resets to 0 at the first window line of each frame.
- pix_addr and pix_rd are registered from stage 0; pix_rd=win. pix_addr holds its last value when pix_rd=0.
- Colour priority at output, highest first:
  1. MARKER_EN && act && x==MARKER_COL → FFFFFF.
  2. win → pix_rgb.
  3. act → BG_RGB.
  4. Otherwise 000000.

## Timing
- Latency is 2 cycles from counter position to hsync/vsync/de/rgb/frame_start. All are delayed as one pipeline so they stay mutually aligned.
- pix_addr/pix_rd lead the output by 1 cycle. RAM read latency is exactly 1 cycle.
- de=1 exactly H_ACTIVE consecutive cycles per active line.
- vsync transitions coincide with output x=0.
- Reset values:
  - x=0, y=0.
  - hsync=vsync=~SYNC_ACTIVE.
  - de=0, rgb=0, frame_start=0, pix_rd=0, pix_addr=0.
  - All sub-counters and the row base are 0.
- First output for pixel (0,0) appears on the 2nd edge after rst_n release, with frame_start=1.
- Reset mid-frame immediately forces all outputs to their reset values and restarts at (0,0). No partial-line residue remains.
- Window touching the right or bottom active edge: the address sequence is truncated. The next line's base remains correct.
- SCALE=1: addr increments every pixel.

## Test plan
- Small geometry (H_ACTIVE=16, H_BLANK=4, V_ACTIVE=8, V_BLANK=3, sync 0/2 each), run=1 → hsync low at output x=16,17; vsync low on lines 8,9; de high 16 cycles per line; frame period 220 cycles; frame_start every 220 cycles.
- WIN 4×2, SCALE=2, origin (2,1), RAM returning data=addr → pix_addr sequence 0,0,1,1,2,2,3,3 on lines 1–2 and 4,4,5,5,6,6,7,7 on lines 3–4. Output rgb equals those values 2 cycles after the counter position; BG elsewhere.
- MARKER_COL=3 inside the window → pixel 3 of every active line is FFFFFF; pix_rd is still asserted there.
- run=0 mid-frame → frame completes, then the generator parks with de=0. run=1 → frame_start 2 cycles after the next counter (0,0).
- rst_n pulsed low at (10,5) → outputs go to reset values asynchronously. After release, frame_start on the 2nd edge.
- Window exceeding the active region (origin (14,7), 4×4, SCALE=1) → pix_rd only at x=14,15 on line 7. The next frame's addresses restart at 0.
